// File: rtl/bist_misr_checker.sv
// BIST response compactor: folds CUT responses into a MISR and latches a PASS/FAIL verdict on FINISH.
// Optional macro BIST_MISR_CNT_CHECK_EN additionally requires the capture count to equal EXP_CNT.
module bist_misr_checker #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(16'h002D),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(16'h0000),
  parameter logic [WIDTH-1:0] GOLDEN  = WIDTH'(16'hA5C3),
  parameter int unsigned      EXP_CNT = 360
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture,
  input  logic [WIDTH-1:0] resp,
  input  logic             finish,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      cap_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sig_nxt;
  logic [WIDTH-1:0] misr_step;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pass_nxt, fail_nxt;
  logic             verdict;

  // One MISR shift: feedback from the MSB through POLY taps, response folded in parallel
  assign misr_step = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ resp;

`ifdef BIST_MISR_CNT_CHECK_EN
  assign verdict = (signature == GOLDEN) && (cap_cnt == CNT_W'(EXP_CNT));
`else
  logic unused_exp_cnt;
  assign unused_exp_cnt = ^CNT_W'(EXP_CNT);
  assign verdict = (signature == GOLDEN);
`endif

  // Next-state and datapath; CLEAR outranks FINISH, FINISH outranks CAPTURE
  always_comb begin
    state_nxt = state;
    sig_nxt   = signature;
    cnt_nxt   = cap_cnt;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = ACTIVE;
          sig_nxt   = SEED;
          cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (clear) begin
          sig_nxt = SEED;
          cnt_nxt = '0;
        end else if (finish) begin
          state_nxt = RESULT;
          pass_nxt  = verdict;
          fail_nxt  = ~verdict;
        end else if (capture) begin
          sig_nxt = misr_step;
          cnt_nxt = (cap_cnt == CNT_MAX) ? cap_cnt : cap_cnt + CNT_W'(1);
        end
      end
      RESULT: begin
        if (clear) begin
          state_nxt = ACTIVE;
          sig_nxt   = SEED;
          cnt_nxt   = '0;
        end else begin
          pass_nxt = pass;
          fail_nxt = fail;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs; status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      signature <= SEED;
      cap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      signature <= sig_nxt;
      cap_cnt   <= cnt_nxt;
      busy      <= (state_nxt == ACTIVE);
      done      <= (state_nxt == RESULT);
      pass      <= pass_nxt;
      fail      <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker, built with GOLDEN=16'h0002 so short streams can hit the golden value.
module tb_bist_misr_checker;

  logic        clk = 1'b0;
  logic        reset, clear, capture, finish;
  logic [15:0] resp;
  logic [15:0] signature;
  logic [15:0] cap_cnt;
  logic        busy, done, pass, fail;

  int checks = 0;
  int errors = 0;

  bist_misr_checker #(
    .WIDTH  (16),
    .POLY   (16'h002D),
    .SEED   (16'h0000),
    .GOLDEN (16'h0002),
    .EXP_CNT(360)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .capture  (capture),
    .resp     (resp),
    .finish   (finish),
    .signature(signature),
    .cap_cnt  (cap_cnt),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic b, input logic d, input logic p, input logic f);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_fail"}, 32'(fail), 32'(f));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; capture = 1'b0; finish = 1'b0; resp = 16'h0000;

    // T1 reset and idle
    cyc(); cyc();
    chk("rst_sig", 32'(signature), 32'h0000);
    chk("rst_cnt", 32'(cap_cnt), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; capture = 1'b1; resp = 16'hFFFF;
    cyc();
    chk("idle_sig", 32'(signature), 32'h0000);
    chk("idle_cnt", 32'(cap_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // T2 compaction math
    capture = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk_flags("clr", 1'b1, 1'b0, 1'b0, 1'b0);
    capture = 1'b1; resp = 16'h0001;
    cyc();
    chk("t2_sig1", 32'(signature), 32'h0001);
    chk("t2_cnt1", 32'(cap_cnt), 32'd1);
    resp = 16'h0000;
    cyc();
    chk("t2_sig2", 32'(signature), 32'h0002);
    chk("t2_cnt2", 32'(cap_cnt), 32'd2);

    // T4 verdict pass
    capture = 1'b0; finish = 1'b1;
    cyc();
    chk_flags("t4_pass", 1'b0, 1'b1, 1'b1, 1'b0);
    // RESULT is frozen against CAPTURE and repeated FINISH
    capture = 1'b1; resp = 16'hFFFF;
    cyc(); cyc();
    chk("res_sig", 32'(signature), 32'h0002);
    chk("res_cnt", 32'(cap_cnt), 32'd2);
    chk_flags("res_hold", 1'b0, 1'b1, 1'b1, 1'b0);

    // T4 rerun with wrong stream
    capture = 1'b0; finish = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("rerun_sig", 32'(signature), 32'h0000);
    chk("rerun_cnt", 32'(cap_cnt), 32'd0);
    chk_flags("rerun", 1'b1, 1'b0, 1'b0, 1'b0);
    capture = 1'b1; resp = 16'h0001;
    cyc();
    resp = 16'h0004;
    cyc();
    chk("t4b_sig", 32'(signature), 32'h0006);
    capture = 1'b0; finish = 1'b1;
    cyc();
    finish = 1'b0;
    chk_flags("t4_fail", 1'b0, 1'b1, 1'b0, 1'b1);

    // T3 feedback from the MSB
    clear = 1'b1;
    cyc();
    clear = 1'b0; capture = 1'b1; resp = 16'h8000;
    cyc();
    chk("t3_msb", 32'(signature), 32'h8000);
    resp = 16'h0000;
    cyc();
    chk("t3_fb", 32'(signature), 32'h002D);
    chk("t3_cnt", 32'(cap_cnt), 32'd2);

    // T5 FINISH beats CAPTURE
    capture = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0; capture = 1'b1; resp = 16'h0001;
    cyc();
    resp = 16'h1234; finish = 1'b1;
    cyc();
    capture = 1'b0; finish = 1'b0;
    chk("t5_sig", 32'(signature), 32'h0001);
    chk("t5_cnt", 32'(cap_cnt), 32'd1);
    chk_flags("t5_fin", 1'b0, 1'b1, 1'b0, 1'b1);

    // T5 CLEAR beats FINISH in ACTIVE
    clear = 1'b1;
    cyc();
    clear = 1'b0; capture = 1'b1; resp = 16'h1234;
    cyc();
    chk("t5_cap", 32'(signature), 32'h1234);
    capture = 1'b0; clear = 1'b1; finish = 1'b1;
    cyc();
    clear = 1'b0; finish = 1'b0;
    chk("t5_clr_sig", 32'(signature), 32'h0000);
    chk("t5_clr_cnt", 32'(cap_cnt), 32'd0);
    chk_flags("t5_clr", 1'b1, 1'b0, 1'b0, 1'b0);

    // T6 matching signature after 359 captures
    capture = 1'b1; resp = 16'h0000;
    for (int i = 0; i < 357; i++) cyc();
    resp = 16'h0001;
    cyc();
    resp = 16'h0000;
    cyc();
    chk("t6_cnt359", 32'(cap_cnt), 32'd359);
    chk("t6_sig359", 32'(signature), 32'h0002);
    capture = 1'b0; finish = 1'b1;
    cyc();
    finish = 1'b0;
`ifdef BIST_MISR_CNT_CHECK_EN
    chk_flags("t6_359", 1'b0, 1'b1, 1'b0, 1'b1);
`else
    chk_flags("t6_359", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    // T6 exact count passes in both builds
    clear = 1'b1;
    cyc();
    clear = 1'b0; capture = 1'b1; resp = 16'h0000;
    for (int i = 0; i < 358; i++) cyc();
    resp = 16'h0001;
    cyc();
    resp = 16'h0000;
    cyc();
    chk("t6_cnt360", 32'(cap_cnt), 32'd360);
    capture = 1'b0; finish = 1'b1;
    cyc();
    finish = 1'b0;
    chk_flags("t6_360", 1'b0, 1'b1, 1'b1, 1'b0);

    // RESET mid-run overrides CLEAR and CAPTURE
    clear = 1'b1;
    cyc();
    clear = 1'b0; capture = 1'b1; resp = 16'h0005;
    cyc();
    chk("mid_sig", 32'(signature), 32'h0005);
    reset = 1'b1; clear = 1'b1;
    cyc();
    chk("mid_rst_sig", 32'(signature), 32'h0000);
    chk("mid_rst_cnt", 32'(cap_cnt), 32'd0);
    chk_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; clear = 1'b0; capture = 1'b0;
    cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
